// File: rtl/clk_div_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// clk_div_pkg : shared types and mode encodings for clk_div_ctrl.  Rev 1.0
// ---------------------------------------------------------------------------
package clk_div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } state_e;

  localparam logic [1:0] MODE_RUN  = 2'b00;
  localparam logic [1:0] MODE_STEP = 2'b01;
  localparam logic [1:0] MODE_HALT = 2'b10;

  // Encoding 2'b11 is not a separate mode; it behaves like HALT.
  function automatic logic is_run_mode(input logic [1:0] m);
    return m == MODE_RUN;
  endfunction

  function automatic logic is_step_mode(input logic [1:0] m);
    return m == MODE_STEP;
  endfunction

endpackage
`default_nettype wire

// File: rtl/clk_div_phase_cnt.sv
`default_nettype none
// ---------------------------------------------------------------------------
// clk_div_phase_cnt : half-period counter, terminal compare, pending reload.
// Rev 1.0
// ---------------------------------------------------------------------------
module clk_div_phase_cnt
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned DEFAULT_HALF = 2500000
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             cnt_en,
  input  logic             cnt_clr,
  input  logic             apply_ok,
  input  logic             load,
  input  logic [CNT_W-1:0] half_period,
  output logic             phase_end,
  output logic [CNT_W-1:0] cur_half
);

  localparam logic [CNT_W-1:0] C_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_DEF_HALF = CNT_W'(DEFAULT_HALF);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] half_q, half_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             pend_v_q, pend_v_d;
  logic             w_tc;
  logic [CNT_W-1:0] w_load_val;

  assign w_tc       = (cnt_q == (half_q - C_ONE));
  assign phase_end  = cnt_en & w_tc;
  assign w_load_val = (half_period == '0) ? C_ONE : half_period;
  assign cur_half   = half_q;

  always_comb begin
    cnt_d    = cnt_q;
    half_d   = half_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;

    if (cnt_clr) begin
      cnt_d = '0;
    end else if (cnt_en) begin
      cnt_d = w_tc ? '0 : cnt_q + C_ONE;
    end

    // Only a value captured before this edge may be applied; a coincident
    // load is captured below and waits for the next apply opportunity.
    if (pend_v_q && apply_ok) begin
      half_d   = pend_q;
      pend_v_d = 1'b0;
    end

    if (load) begin
      pend_d   = w_load_val;
      pend_v_d = 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst) begin
      cnt_q    <= '0;
      half_q   <= C_DEF_HALF;
      pend_q   <= C_DEF_HALF;
      pend_v_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      half_q   <= half_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/clk_div_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// clk_div_ctrl : glitch-free programmable clock divider with run/step/halt.
// Rev 1.0
// ---------------------------------------------------------------------------
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned DEFAULT_HALF = 2500000
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic [CNT_W-1:0] half_period,
  input  logic             load,
  input  logic [1:0]       mode,
  input  logic             step_req,
  output logic             clk_out,
  output logic             rise_tick,
  output logic             busy,
  output logic [CNT_W-1:0] cur_half
);

  state_e state_q, state_d;
  logic   clk_out_q, clk_out_d;
  logic   rise_tick_q, rise_tick_d;
  logic   cnt_en, cnt_clr, apply_ok, phase_end;

  clk_div_phase_cnt #(
    .CNT_W        (CNT_W),
    .DEFAULT_HALF (DEFAULT_HALF)
  ) u_phase_cnt (
    .clk_in      (clk_in),
    .rst         (rst),
    .cnt_en      (cnt_en),
    .cnt_clr     (cnt_clr),
    .apply_ok    (apply_ok),
    .load        (load),
    .half_period (half_period),
    .phase_end   (phase_end),
    .cur_half    (cur_half)
  );

  always_comb begin
    state_d   = state_q;
    clk_out_d = clk_out_q;
    cnt_en    = (state_q != ST_IDLE);
    cnt_clr   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        clk_out_d = 1'b0;
        cnt_clr   = 1'b1;
        if (is_run_mode(mode)) begin
          state_d = ST_RUN;
        end else if (is_step_mode(mode) && step_req) begin
          state_d = ST_STEP;
        end
      end
      ST_RUN: begin
        if (!is_run_mode(mode) && !clk_out_q) begin
          state_d = ST_IDLE;
          cnt_clr = 1'b1;
        end else if (phase_end) begin
          clk_out_d = ~clk_out_q;
          // A pending halt only takes effect once the high phase has ended.
          if (!is_run_mode(mode) && clk_out_q) begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_STEP: begin
        if (phase_end) begin
          clk_out_d = ~clk_out_q;
          if (clk_out_q) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d   = ST_IDLE;
        clk_out_d = 1'b0;
        cnt_clr   = 1'b1;
      end
    endcase

    // New half-period lands only at a real toggle (or while idle), so no
    // phase is ever cut short.
    apply_ok    = (state_q == ST_IDLE) || (clk_out_d != clk_out_q);
    rise_tick_d = clk_out_d & ~clk_out_q;
  end

  always_ff @(posedge clk_in) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      clk_out_q   <= 1'b0;
      rise_tick_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_out_q   <= clk_out_d;
      rise_tick_q <= rise_tick_d;
    end
  end

  assign clk_out   = clk_out_q;
  assign rise_tick = rise_tick_q;
  assign busy      = (state_q == ST_STEP);

endmodule
`default_nettype wire

// File: tb/tb_clk_div_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_clk_div_ctrl : directed self-checking bench for clk_div_ctrl.  Rev 1.0
// ---------------------------------------------------------------------------
module tb_clk_div_ctrl;

  localparam int CNT_W = 16;

  logic             clk_in = 1'b0;
  logic             rst;
  logic [CNT_W-1:0] half_period;
  logic             load;
  logic [1:0]       mode;
  logic             step_req;
  logic             clk_out;
  logic             rise_tick;
  logic             busy;
  logic [CNT_W-1:0] cur_half;

  int checks = 0;
  int errors = 0;

  clk_div_ctrl #(
    .CNT_W        (CNT_W),
    .DEFAULT_HALF (3)
  ) dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .half_period (half_period),
    .load        (load),
    .mode        (mode),
    .step_req    (step_req),
    .clk_out     (clk_out),
    .rise_tick   (rise_tick),
    .busy        (busy),
    .cur_half    (cur_half)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  initial begin
    rst = 1'b0; mode = 2'b00; load = 1'b0; half_period = '0; step_req = 1'b0;
    tick(2);
    chk("rst_clk",   32'(clk_out), 0);
    chk("rst_rise",  32'(rise_tick), 0);
    chk("rst_busy",  32'(busy), 0);
    chk("rst_half",  32'(cur_half), 3);

    // RUN at H=3; edge E is the first edge with rst high
    rst = 1'b1;
    tick(1);  chk("run_E0_clk", 32'(clk_out), 0);
    tick(2);  chk("run_E2_clk", 32'(clk_out), 0);
    tick(1);  chk("run_E3_clk", 32'(clk_out), 1);
              chk("run_E3_rise", 32'(rise_tick), 1);
    tick(1);  chk("run_E4_clk", 32'(clk_out), 1);
              chk("run_E4_rise", 32'(rise_tick), 0);
    tick(2);  chk("run_E6_clk", 32'(clk_out), 0);
    tick(3);  chk("run_E9_clk", 32'(clk_out), 1);
              chk("run_E9_rise", 32'(rise_tick), 1);

    // load 5 mid-low-phase: current phase stays 3
    tick(3);  chk("ld5_E12_clk", 32'(clk_out), 0);
    tick(1);  half_period = 16'd5; load = 1'b1;
    tick(1);  load = 1'b0;
              chk("ld5_E14_half", 32'(cur_half), 3);
              chk("ld5_E14_clk", 32'(clk_out), 0);
    tick(1);  chk("ld5_E15_clk", 32'(clk_out), 1);
              chk("ld5_E15_half", 32'(cur_half), 5);
    tick(4);  chk("ld5_E19_clk", 32'(clk_out), 1);
    tick(1);  chk("ld5_E20_clk", 32'(clk_out), 0);
    tick(4);  chk("ld5_E24_clk", 32'(clk_out), 0);
    tick(1);  chk("ld5_E25_clk", 32'(clk_out), 1);

    // load 0 clamps to 1
    half_period = 16'd0; load = 1'b1;
    tick(1);  load = 1'b0;
              chk("ld0_E26_half", 32'(cur_half), 5);
    tick(4);  chk("ld0_E30_clk", 32'(clk_out), 0);
              chk("ld0_E30_half", 32'(cur_half), 1);
    tick(1);  chk("ld0_E31_clk", 32'(clk_out), 1);
              chk("ld0_E31_rise", 32'(rise_tick), 1);
    tick(1);  chk("ld0_E32_clk", 32'(clk_out), 0);
    tick(1);  chk("ld0_E33_clk", 32'(clk_out), 1);

    // load coincident with a toggle edge applies one toggle later
    half_period = 16'd4; load = 1'b1;
    tick(1);  load = 1'b0;
              chk("ldtg_E34_clk", 32'(clk_out), 0);
              chk("ldtg_E34_half", 32'(cur_half), 1);
    tick(1);  chk("ldtg_E35_clk", 32'(clk_out), 1);
              chk("ldtg_E35_half", 32'(cur_half), 4);

    // HALT one cycle after the rise: high phase completes
    mode = 2'b10;
    tick(1);  chk("hlt_E36_clk", 32'(clk_out), 1);
    tick(2);  chk("hlt_E38_clk", 32'(clk_out), 1);
    tick(1);  chk("hlt_E39_clk", 32'(clk_out), 0);
    tick(8);  chk("hlt_E47_clk", 32'(clk_out), 0);
              chk("hlt_E47_half", 32'(cur_half), 4);

    // HALT (encoding 11) during the low phase: no rise at all
    mode = 2'b00;
    tick(3);  mode = 2'b11;
    for (int k = 0; k < 8; k++) begin
      tick(1);
      chk("hltlow_clk", 32'(clk_out), 0);
    end

    // single step, H=4, with a second request while busy
    mode = 2'b01; step_req = 1'b1;
    tick(1);  step_req = 1'b0;
    for (int k = 0; k <= 12; k++) begin
      if (k > 0) tick(1);
      chk("step_busy", 32'(busy), (k <= 7) ? 1 : 0);
      chk("step_clk",  32'(clk_out), (k >= 4 && k <= 7) ? 1 : 0);
      chk("step_rise", 32'(rise_tick), (k == 4) ? 1 : 0);
      if (k == 1) step_req = 1'b1;
      if (k == 2) step_req = 1'b0;
    end

    // load while idle applies on the next edge
    half_period = 16'd6; load = 1'b1;
    tick(1);  load = 1'b0;
              chk("idle_ld_L0", 32'(cur_half), 4);
    tick(1);  chk("idle_ld_L1", 32'(cur_half), 6);

    // reset while clk_out high with a load pending
    mode = 2'b00;
    tick(1);  chk("rr_G0_clk", 32'(clk_out), 0);
    tick(6);  chk("rr_G6_clk", 32'(clk_out), 1);
    half_period = 16'd7; load = 1'b1;
    tick(1);  load = 1'b0; rst = 1'b0;
    tick(1);  rst = 1'b1; mode = 2'b10;
              chk("rr_clk",  32'(clk_out), 0);
              chk("rr_busy", 32'(busy), 0);
              chk("rr_half", 32'(cur_half), 3);
    tick(2);  chk("rr_pend_dropped", 32'(cur_half), 3);
              chk("rr_idle_clk", 32'(clk_out), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
